// File: rtl/polytris_pkg.sv
// Shared definitions for the Polytris scoring and level logic.
// Holds the line-clear point values, the top level, the level_tracker
// FSM state type and the clear-size to base-points lookup.
package polytris_pkg;

  localparam logic [10:0] PTS_SINGLE = 11'd40;
  localparam logic [10:0] PTS_DOUBLE = 11'd100;
  localparam logic [10:0] PTS_TRIPLE = 11'd300;
  localparam logic [10:0] PTS_TETRIS = 11'd1200;

  localparam logic [2:0]  LEVEL_MAX  = 3'd7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    LVL  = 2'd2
  } lt_state_t;

  // Base points for a clear of n rows; anything outside 1..4 scores nothing.
  function automatic logic [10:0] line_points(input logic [2:0] n);
    case (n)
      3'd1:    line_points = PTS_SINGLE;
      3'd2:    line_points = PTS_DOUBLE;
      3'd3:    line_points = PTS_TRIPLE;
      3'd4:    line_points = PTS_TETRIS;
      default: line_points = '0;
    endcase
  endfunction

endpackage

// File: rtl/score_sat_add.sv
// Combinational saturating adder.
// Ports:
//   a, b : W-bit unsigned operands
//   sum  : a + b, clamped to all-ones on overflow
module score_sat_add #(
  parameter int unsigned W = 20
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] sum
);

  logic [W:0] full;

  always_comb begin
    full = {1'b0, a} + {1'b0, b};
    sum  = full[W] ? '1 : full[W-1:0];
  end

endmodule

// File: rtl/level_tracker.sv
// Line-count / level / score tracker feeding the gravity tick generator.
// A clear report is scored by adding its base points (level+1) times in a
// small FSM (IDLE -> MUL -> LVL), then the line counters and level update.
//
// Ports:
//   CLK, RESET_N    : clock, synchronous active-low reset
//   start           : begin a new game at start_level (beats everything but reset)
//   start_level     : level loaded on start
//   game_over       : blocks new clears and soft-drop ticks
//   clear_valid     : one-cycle clear report, clear_lines rows (1..4 legal)
//   soft_drop_tick  : one pulse per soft-drop step
//   busy            : clear being processed, clear_valid dropped meanwhile
//   level           : current level 0..7
//   lines_total     : saturating total of rows cleared
//   score           : saturating score
//   level_up        : one-cycle pulse on level increment
//
// Build option: POLYTRIS_SOFT_DROP_BONUS_EN -- when defined, each soft-drop
// tick adds 1 to score (any state, unless game_over). Otherwise the tick
// input is ignored.
module level_tracker
  import polytris_pkg::*;
#(
  parameter int unsigned LINES_PER_LEVEL = 10,
  parameter int unsigned SCORE_W         = 20,
  parameter int unsigned LINES_W         = 10
) (
  input  logic               CLK,
  input  logic               RESET_N,
  input  logic               start,
  input  logic [2:0]         start_level,
  input  logic               game_over,
  input  logic               clear_valid,
  input  logic [2:0]         clear_lines,
  input  logic               soft_drop_tick,
  output logic               busy,
  output logic [2:0]         level,
  output logic [LINES_W-1:0] lines_total,
  output logic [SCORE_W-1:0] score,
  output logic               level_up
);

  // Wide enough for (LINES_PER_LEVEL-1) + 4 without overflow.
  localparam int unsigned       LIL_W = $clog2(LINES_PER_LEVEL + 8);
  localparam logic [LIL_W-1:0]  LPL_V = LIL_W'(LINES_PER_LEVEL);

  lt_state_t          state, state_next;
  logic [10:0]        base_q;
  logic [2:0]         size_q;
  logic [3:0]         reps_q;
  logic [LIL_W-1:0]   lines_in_level;

  logic               accept;
  logic               soft_add;
  logic [SCORE_W-1:0] score_inc, score_sum;
  logic [LINES_W-1:0] lines_sum;
  logic [LIL_W-1:0]   lil_sum, lil_next;
  logic               lil_wrap;

`ifdef POLYTRIS_SOFT_DROP_BONUS_EN
  assign soft_add = soft_drop_tick && !game_over;
`else
  logic unused_soft_drop_tick;
  assign unused_soft_drop_tick = soft_drop_tick;
  assign soft_add = 1'b0;
`endif

  always_comb begin
    accept = (state == IDLE) && clear_valid && !game_over &&
             (clear_lines >= 3'd1) && (clear_lines <= 3'd4);
    busy   = (state != IDLE);
  end

  // A soft tick landing on a MUL cycle is folded into the same add.
  always_comb begin
    score_inc = '0;
    if (state == MUL)
      score_inc = SCORE_W'(base_q);
    score_inc = score_inc + SCORE_W'(soft_add);
  end

  score_sat_add #(.W(SCORE_W)) u_score_add (
    .a   (score),
    .b   (score_inc),
    .sum (score_sum)
  );

  score_sat_add #(.W(LINES_W)) u_lines_add (
    .a   (lines_total),
    .b   (LINES_W'(size_q)),
    .sum (lines_sum)
  );

  // Level progress keeps the overshoot past the threshold, even at the top level.
  always_comb begin
    lil_sum  = lines_in_level + LIL_W'(size_q);
    lil_wrap = (lil_sum >= LPL_V);
    lil_next = lil_wrap ? (lil_sum - LPL_V) : lil_sum;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (accept) state_next = MUL;
      MUL:     if (reps_q == 4'd1) state_next = LVL;
      LVL:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      state          <= IDLE;
      base_q         <= '0;
      size_q         <= '0;
      reps_q         <= '0;
      lines_in_level <= '0;
      level          <= '0;
      lines_total    <= '0;
      score          <= '0;
      level_up       <= 1'b0;
    end else if (start) begin
      state          <= IDLE;
      lines_in_level <= '0;
      level          <= start_level;
      lines_total    <= '0;
      score          <= '0;
      level_up       <= 1'b0;
    end else begin
      state    <= state_next;
      level_up <= 1'b0;
      score    <= score_sum;

      if (accept) begin
        base_q <= line_points(clear_lines);
        size_q <= clear_lines;
        reps_q <= {1'b0, level} + 4'd1;
      end

      if (state == MUL)
        reps_q <= reps_q - 4'd1;

      if (state == LVL) begin
        lines_total    <= lines_sum;
        lines_in_level <= lil_next;
        if (lil_wrap && (level != LEVEL_MAX)) begin
          level    <= level + 3'd1;
          level_up <= 1'b1;
        end
      end
    end
  end

endmodule
